// File: rtl/ball_motion.sv
// Ball position/direction owner: move-tick timer, crash-driven direction flips, clamped stepping.
// Optional floor-miss handling (oMiss port) is enabled by defining BALL_MISS_EN.
module ball_motion #(
   parameter int unsigned TICK_DIV = 833333,
   parameter int unsigned STEP     = 2,
   parameter int unsigned X_MIN    = 10,
   parameter int unsigned X_MAX    = 630,
   parameter int unsigned Y_MIN    = 10,
   parameter int unsigned Y_MAX    = 470,
   parameter int unsigned X_INIT   = 320,
   parameter int unsigned Y_INIT   = 240
) (
   input  logic       iClk,
   input  logic       iRst_n,
   input  logic [3:0] iCrash,
   input  logic       iStart,
   input  logic       iPause,
   output logic [9:0] oBall_x,
   output logic [9:0] oBall_y,
   output logic       oDir_x,
   output logic       oDir_y,
   output logic       oBounce,
   output logic       oRunning
`ifdef BALL_MISS_EN
   ,
   output logic       oMiss
`endif
);

   localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_PAUSE = 2'd2;

   localparam logic signed [10:0] S_STEP  = 11'(STEP);
   localparam logic signed [10:0] S_X_MIN = 11'(X_MIN);
   localparam logic signed [10:0] S_X_MAX = 11'(X_MAX);
   localparam logic signed [10:0] S_Y_MIN = 11'(Y_MIN);
   localparam logic signed [10:0] S_Y_MAX = 11'(Y_MAX);

   logic [1:0]       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [9:0]       r_x;
   logic [9:0]       r_y;
   logic             r_dx;
   logic             r_dy;
   logic             r_bounce;
`ifdef BALL_MISS_EN
   logic             r_miss;
   logic             w_miss;
`endif

   logic              w_tick;
   logic              w_dx_new;
   logic              w_dy_new;
   logic signed [10:0] w_x_sum;
   logic signed [10:0] w_y_sum;
   logic [9:0]        w_x_nxt;
   logic [9:0]        w_y_nxt;

   // Pause freezes the counter in the same cycle it is seen, so no tick fires then.
   assign w_tick = (r_state == ST_RUN) && !iPause && (r_cnt == CNT_LAST);

`ifdef BALL_MISS_EN
   assign w_miss = w_tick && iCrash[0] && (r_y >= 10'(Y_MAX - STEP));
`endif

   always_comb begin
      w_dx_new = r_dx;
      w_dy_new = r_dy;
      if (iCrash[3] && !iCrash[2]) w_dx_new = 1'b1;
      else if (iCrash[2] && !iCrash[3]) w_dx_new = 1'b0;
      if (iCrash[1] && !iCrash[0]) w_dy_new = 1'b1;
      else if (iCrash[0] && !iCrash[1]) w_dy_new = 1'b0;
   end

   // Step with the freshly resolved directions, then clamp to the play field.
   always_comb begin
      w_x_sum = $signed({1'b0, r_x}) + (w_dx_new ? S_STEP : -S_STEP);
      w_y_sum = $signed({1'b0, r_y}) + (w_dy_new ? S_STEP : -S_STEP);
      if (w_x_sum < S_X_MIN)      w_x_nxt = 10'(X_MIN);
      else if (w_x_sum > S_X_MAX) w_x_nxt = 10'(X_MAX);
      else                        w_x_nxt = w_x_sum[9:0];
      if (w_y_sum < S_Y_MIN)      w_y_nxt = 10'(Y_MIN);
      else if (w_y_sum > S_Y_MAX) w_y_nxt = 10'(Y_MAX);
      else                        w_y_nxt = w_y_sum[9:0];
   end

   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         r_state  <= ST_IDLE;
         r_cnt    <= '0;
         r_x      <= 10'(X_INIT);
         r_y      <= 10'(Y_INIT);
         r_dx     <= 1'b1;
         r_dy     <= 1'b0;
         r_bounce <= 1'b0;
`ifdef BALL_MISS_EN
         r_miss   <= 1'b0;
`endif
      end else begin
         r_bounce <= 1'b0;
`ifdef BALL_MISS_EN
         r_miss   <= 1'b0;
`endif
         case (r_state)
            ST_IDLE: begin
               r_cnt <= '0;
               if (iStart && !iPause) r_state <= ST_RUN;
            end
            ST_RUN: begin
               if (iPause) begin
                  r_state <= ST_PAUSE;
`ifdef BALL_MISS_EN
               end else if (w_miss) begin
                  r_state <= ST_IDLE;
                  r_cnt   <= '0;
                  r_x     <= 10'(X_INIT);
                  r_y     <= 10'(Y_INIT);
                  r_dx    <= 1'b1;
                  r_dy    <= 1'b0;
                  r_miss  <= 1'b1;
`endif
               end else if (w_tick) begin
                  r_cnt    <= '0;
                  r_dx     <= w_dx_new;
                  r_dy     <= w_dy_new;
                  r_x      <= w_x_nxt;
                  r_y      <= w_y_nxt;
                  r_bounce <= (w_dx_new != r_dx) || (w_dy_new != r_dy);
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            ST_PAUSE: begin
               if (!iPause) r_state <= ST_RUN;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign oBall_x  = r_x;
   assign oBall_y  = r_y;
   assign oDir_x   = r_dx;
   assign oDir_y   = r_dy;
   assign oBounce  = r_bounce;
   assign oRunning = (r_state == ST_RUN);
`ifdef BALL_MISS_EN
   assign oMiss    = r_miss;
`endif

endmodule
